// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler
// SCAN call scheduler for a small elevator. It latches cabin and hall calls and picks a
// travel direction. It drives registered motor and door commands and stops at each
// requested floor. A stalled move sets a sticky fault.
// Optional feature macro: DOOR_HOLD_EN adds the doorHold input, which keeps the door open.
module elevator_call_scheduler #(
    parameter int FLOORS       = 3,
    parameter int DOOR_CYCLES  = 8,
    parameter int MOVE_TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [FLOORS-1:0] inCall,
    input  logic [FLOORS-1:0] outCall,
    input  logic [FLOORS-1:0] loc,
`ifdef DOOR_HOLD_EN
    input  logic              doorHold,
`endif
    output logic [1:0]        motor,
    output logic [FLOORS-1:0] door,
    output logic [FLOORS-1:0] pending,
    output logic [FLOORS-1:0] curFloor,
    output logic              fault
);

    localparam int TW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
    localparam int CW = (MOVE_TIMEOUT > 2) ? $clog2(MOVE_TIMEOUT) : 1;
    localparam logic [TW-1:0]     TIMER_INIT = TW'(DOOR_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_MAX    = CW'(MOVE_TIMEOUT - 1);
    localparam logic [FLOORS-1:0] BOT        = FLOORS'(1);
    localparam logic [FLOORS-1:0] TOP        = BOT << (FLOORS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DOOR,
        S_FAULT
    } state_t;

    state_t            r_state;
    logic              r_dir;        // 1 = up, 0 = down
    logic [FLOORS-1:0] r_pending;
    logic [FLOORS-1:0] r_curFloor;
    logic [TW-1:0]     r_timer;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_motor;
    logic [FLOORS-1:0] r_door;
    logic              r_fault;

    state_t            w_next_state;
    logic              w_next_dir;
    logic [TW-1:0]     w_timer_next;
    logic [CW-1:0]     w_cnt_next;
    logic [FLOORS-1:0] w_pend_next;
    logic [FLOORS-1:0] w_cur_next;
    logic [FLOORS-1:0] w_calls;
    logic [FLOORS-1:0] w_below_mask;
    logic [FLOORS-1:0] w_above_mask;
    logic              w_loc_onehot;
    logic              w_new_loc;
    logic              w_above;
    logic              w_below;
    logic              w_ahead;
    logic              w_behind;
    logic              w_hold;

`ifdef DOOR_HOLD_EN
    assign w_hold = doorHold;
`else
    assign w_hold = 1'b0;
`endif

    // Decode floor sensors and split pending calls into above/below the current floor.
    always_comb begin
        w_calls      = inCall | outCall;
        w_loc_onehot = (loc != '0) && ((loc & (loc - BOT)) == '0);
        w_cur_next   = w_loc_onehot ? loc : r_curFloor;
        w_new_loc    = w_loc_onehot && (loc != r_curFloor);
        w_below_mask = r_curFloor - BOT;
        w_above_mask = ~(r_curFloor | w_below_mask);
        w_above      = |(r_pending & w_above_mask);
        w_below      = |(r_pending & w_below_mask);
        w_ahead      = r_dir ? w_above : w_below;
        w_behind     = r_dir ? w_below : w_above;
    end

    // Next-state logic: SCAN direction choice, stop detection, door timer and move timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_dir   = r_dir;
        w_timer_next = r_timer;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if ((r_pending & r_curFloor) != '0) begin
                    w_next_state = S_DOOR;
                    w_timer_next = TIMER_INIT;
                end else if (w_above && (r_dir || !w_below)) begin
                    w_next_state = S_UP;
                    w_next_dir   = 1'b1;
                    w_cnt_next   = '0;
                end else if (w_below) begin
                    w_next_state = S_DOWN;
                    w_next_dir   = 1'b0;
                    w_cnt_next   = '0;
                end
            end
            S_UP, S_DOWN: begin
                // End floors force a stop so the cabin never overruns the shaft.
                if (w_loc_onehot && (((loc & r_pending) != '0) ||
                        ((r_state == S_UP) && (loc == TOP)) ||
                        ((r_state == S_DOWN) && (loc == BOT)))) begin
                    w_next_state = S_DOOR;
                    w_timer_next = TIMER_INIT;
                end else if (w_new_loc) begin
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_MAX) begin
                    w_next_state = S_FAULT;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            S_DOOR: begin
                // A fresh call at this floor is served by keeping the door open longer.
                if (((w_calls & w_cur_next) != '0) || w_hold) begin
                    w_timer_next = TIMER_INIT;
                end else if (r_timer == '0) begin
                    if (w_ahead) begin
                        w_next_state = r_dir ? S_UP : S_DOWN;
                        w_cnt_next   = '0;
                    end else if (w_behind) begin
                        w_next_state = r_dir ? S_DOWN : S_UP;
                        w_next_dir   = ~r_dir;
                        w_cnt_next   = '0;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end else begin
                    w_timer_next = r_timer - TW'(1);
                end
            end
            S_FAULT: begin
                w_next_state = S_FAULT;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        w_pend_next = (r_pending | w_calls) &
                      ~((w_next_state == S_DOOR) ? w_cur_next : '0);
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Call latch, floor tracking, timers and registered Moore outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dir      <= 1'b1;
            r_pending  <= '0;
            r_curFloor <= BOT;
            r_timer    <= '0;
            r_cnt      <= '0;
            r_motor    <= 2'b00;
            r_door     <= '0;
            r_fault    <= 1'b0;
        end else begin
            r_dir      <= w_next_dir;
            r_pending  <= w_pend_next;
            r_curFloor <= w_cur_next;
            r_timer    <= w_timer_next;
            r_cnt      <= w_cnt_next;
            r_motor    <= (w_next_state == S_UP)   ? 2'b10 :
                          (w_next_state == S_DOWN) ? 2'b11 : 2'b00;
            r_door     <= (w_next_state == S_DOOR) ? w_cur_next : '0;
            r_fault    <= (w_next_state == S_FAULT);
        end
    end

    assign motor    = r_motor;
    assign door     = r_door;
    assign pending  = r_pending;
    assign curFloor = r_curFloor;
    assign fault    = r_fault;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Testbench for elevator_call_scheduler: directed scenarios plus a randomized run
// against a floor-level behavioural model with a simple moving-cabin plant.
module tb_elevator_call_scheduler;

    localparam int M_IDLE  = 0;
    localparam int M_UP    = 1;
    localparam int M_DOWN  = 2;
    localparam int M_DOOR  = 3;
    localparam int M_FAULT = 4;

    logic       CLK;
    logic       RST;
    logic [2:0] inCall;
    logic [2:0] outCall;
    logic [2:0] loc;
`ifdef DOOR_HOLD_EN
    logic       doorHold;
`endif
    logic [1:0] motor;
    logic [2:0] door;
    logic [2:0] pending;
    logic [2:0] curFloor;
    logic       fault;

    int checks = 0;
    int errors = 0;

    // reference model state (floor numbers 0..2, bottom = 0)
    int       m_state;
    int       m_floor;
    int       m_timer;
    int       m_cnt;
    bit       m_dir;
    bit [2:0] m_pend;

    elevator_call_scheduler #(
        .FLOORS(3),
        .DOOR_CYCLES(8),
        .MOVE_TIMEOUT(1024)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .inCall(inCall),
        .outCall(outCall),
        .loc(loc),
`ifdef DOOR_HOLD_EN
        .doorHold(doorHold),
`endif
        .motor(motor),
        .door(door),
        .pending(pending),
        .curFloor(curFloor),
        .fault(fault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_state = M_IDLE;
        m_floor = 0;
        m_timer = 0;
        m_cnt   = 0;
        m_dir   = 1'b1;
        m_pend  = 3'b000;
    endtask

    task automatic model_step();
        bit [2:0] c;
        int lf;
        int nf;
        int ns;
        bit above;
        bit below;
        bit ahead;
        bit behind;
        bit hold;
        c  = inCall | outCall;
        lf = -1;
        if (loc == 3'b001) lf = 0;
        else if (loc == 3'b010) lf = 1;
        else if (loc == 3'b100) lf = 2;
        nf = (lf >= 0) ? lf : m_floor;
        above = 1'b0;
        below = 1'b0;
        for (int f = 0; f < 3; f++) begin
            if (m_pend[f] && f > m_floor) above = 1'b1;
            if (m_pend[f] && f < m_floor) below = 1'b1;
        end
        hold = 1'b0;
`ifdef DOOR_HOLD_EN
        hold = doorHold;
`endif
        ns = m_state;
        case (m_state)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    ns = M_DOOR; m_timer = 7;
                end else if (above && (m_dir || !below)) begin
                    ns = M_UP; m_dir = 1'b1; m_cnt = 0;
                end else if (below) begin
                    ns = M_DOWN; m_dir = 1'b0; m_cnt = 0;
                end
            end
            M_UP, M_DOWN: begin
                if (lf >= 0 && (m_pend[lf] || (m_state == M_UP && lf == 2) ||
                                (m_state == M_DOWN && lf == 0))) begin
                    ns = M_DOOR; m_timer = 7;
                end else if (lf >= 0 && lf != m_floor) begin
                    m_cnt = 0;
                end else if (m_cnt == 1023) begin
                    ns = M_FAULT;
                end else begin
                    m_cnt++;
                end
            end
            M_DOOR: begin
                ahead  = m_dir ? above : below;
                behind = m_dir ? below : above;
                if (c[nf] || hold) begin
                    m_timer = 7;
                end else if (m_timer == 0) begin
                    if (ahead) begin
                        ns = m_dir ? M_UP : M_DOWN; m_cnt = 0;
                    end else if (behind) begin
                        ns = m_dir ? M_DOWN : M_UP; m_dir = !m_dir; m_cnt = 0;
                    end else begin
                        ns = M_IDLE;
                    end
                end else begin
                    m_timer--;
                end
            end
            default: ns = m_state;
        endcase
        m_pend = m_pend | c;
        if (ns == M_DOOR) m_pend[nf] = 1'b0;
        m_floor = nf;
        m_state = ns;
    endtask

    task automatic step_clk();
        @(posedge CLK);
        if (!RST) model_step();
        #1;
    endtask

    task automatic apply_reset();
        inCall  = 3'b000;
        outCall = 3'b000;
        loc     = 3'b001;
`ifdef DOOR_HOLD_EN
        doorHold = 1'b0;
`endif
        RST = 1'b1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // stimulus only: from reset, ride up to floor 2 on a cabin call and open the door there
    task automatic goto_floor2();
        apply_reset();
        inCall = 3'b010;
        step_clk();
        inCall = 3'b000;
        step_clk();
        loc = 3'b000;
        step_clk();
        loc = 3'b010;
        step_clk();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (motor !== 2'b00) begin errors++; $display("FAIL reset_motor: got %b expected 00", motor); end
        checks++; if (door !== 3'b000) begin errors++; $display("FAIL reset_door: got %b expected 000", door); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b expected 000", pending); end
        checks++; if (curFloor !== 3'b001) begin errors++; $display("FAIL reset_curFloor: got %b expected 001", curFloor); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault); end
    endtask

    task automatic test_up_sweep();
        int open_cnt;
        apply_reset();
        inCall = 3'b100;
        step_clk();
        inCall = 3'b000;
        checks++; if (pending !== 3'b100) begin errors++; $display("FAIL sweep_latch: got %b expected 100", pending); end
        checks++; if (motor !== 2'b00) begin errors++; $display("FAIL sweep_motor_n: got %b expected 00", motor); end
        step_clk();
        checks++; if (motor !== 2'b10) begin errors++; $display("FAIL sweep_motor_up: got %b expected 10", motor); end
        loc = 3'b000;
        repeat (3) step_clk();
        loc = 3'b010;
        step_clk();
        checks++; if (motor !== 2'b10) begin errors++; $display("FAIL sweep_pass2: got %b expected 10", motor); end
        checks++; if (curFloor !== 3'b010) begin errors++; $display("FAIL sweep_cur2: got %b expected 010", curFloor); end
        loc = 3'b000;
        repeat (2) step_clk();
        loc = 3'b100;
        step_clk();
        checks++; if (motor !== 2'b00) begin errors++; $display("FAIL sweep_stop: got %b expected 00", motor); end
        checks++; if (door !== 3'b100) begin errors++; $display("FAIL sweep_door: got %b expected 100", door); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL sweep_served: got %b expected 000", pending); end
        open_cnt = 0;
        while (door == 3'b100 && open_cnt < 40) begin step_clk(); open_cnt++; end
        checks++; if (open_cnt != 8) begin errors++; $display("FAIL sweep_door_len: got %0d expected 8", open_cnt); end
        step_clk();
        checks++; if (motor !== 2'b00 || door !== 3'b000) begin errors++; $display("FAIL sweep_idle: got motor=%b door=%b expected 00/000", motor, door); end
    endtask

    task automatic test_hall_call_here();
        int open_cnt;
        apply_reset();
        outCall = 3'b001;
        step_clk();
        outCall = 3'b000;
        checks++; if (door !== 3'b000 || pending !== 3'b001) begin errors++; $display("FAIL here_latch: got door=%b pending=%b expected 000/001", door, pending); end
        step_clk();
        checks++; if (door !== 3'b001) begin errors++; $display("FAIL here_door: got %b expected 001", door); end
        checks++; if (motor !== 2'b00) begin errors++; $display("FAIL here_motor: got %b expected 00", motor); end
        checks++; if (pending !== 3'b000) begin errors++; $display("FAIL here_clear: got %b expected 000", pending); end
        open_cnt = 0;
        while (door == 3'b001 && open_cnt < 40) begin step_clk(); open_cnt++; end
        checks++; if (open_cnt != 8) begin errors++; $display("FAIL here_door_len: got %0d expected 8", open_cnt); end
    endtask

    task automatic test_scan_priority();
        goto_floor2();
        repeat (8) step_clk();
        checks++; if (door !== 3'b000 || motor !== 2'b00) begin errors++; $display("FAIL scan_idle2: got door=%b motor=%b expected 000/00", door, motor); end
        inCall = 3'b101;
        step_clk();
        inCall = 3'b000;
        checks++; if (pending !== 3'b101) begin errors++; $display("FAIL scan_latch: got %b expected 101", pending); end
        step_clk();
        checks++; if (motor !== 2'b10) begin errors++; $display("FAIL scan_up_first: got %b expected 10", motor); end
        loc = 3'b000;
        step_clk();
        loc = 3'b100;
        step_clk();
        checks++; if (door !== 3'b100 || pending !== 3'b001) begin errors++; $display("FAIL scan_top: got door=%b pending=%b expected 100/001", door, pending); end
        repeat (7) step_clk();
        checks++; if (door !== 3'b100) begin errors++; $display("FAIL scan_top_open: got %b expected 100", door); end
        step_clk();
        checks++; if (motor !== 2'b11 || door !== 3'b000) begin errors++; $display("FAIL scan_reverse: got motor=%b door=%b expected 11/000", motor, door); end
        loc = 3'b000;
        step_clk();
        loc = 3'b010;
        step_clk();
        checks++; if (motor !== 2'b11) begin errors++; $display("FAIL scan_pass2_down: got %b expected 11", motor); end
        loc = 3'b000;
        step_clk();
        loc = 3'b001;
        step_clk();
        checks++; if (door !== 3'b001 || motor !== 2'b00 || pending !== 3'b000) begin errors++; $display("FAIL scan_bottom: got door=%b motor=%b pending=%b expected 001/00/000", door, motor, pending); end
    endtask

    task automatic test_door_restart();
        int open_cnt;
        goto_floor2();
        repeat (6) step_clk();
        checks++; if (door !== 3'b010) begin errors++; $display("FAIL restart_open: got %b expected 010", door); end
        outCall = 3'b010;
        step_clk();
        outCall = 3'b000;
        checks++; if (door !== 3'b010 || pending !== 3'b000) begin errors++; $display("FAIL restart_served: got door=%b pending=%b expected 010/000", door, pending); end
        open_cnt = 0;
        while (door == 3'b010 && open_cnt < 40) begin step_clk(); open_cnt++; end
        checks++; if (open_cnt != 8) begin errors++; $display("FAIL restart_len: got %0d expected 8", open_cnt); end
    endtask

    task automatic test_timeout();
        apply_reset();
        inCall = 3'b100;
        step_clk();
        inCall = 3'b000;
        step_clk();
        loc = 3'b000;
        repeat (1023) step_clk();
        checks++; if (fault !== 1'b0 || motor !== 2'b10) begin errors++; $display("FAIL timeout_early: got fault=%b motor=%b expected 0/10", fault, motor); end
        step_clk();
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL timeout_fault: got %b expected 1", fault); end
        checks++; if (motor !== 2'b00 || door !== 3'b000) begin errors++; $display("FAIL timeout_outputs: got motor=%b door=%b expected 00/000", motor, door); end
        inCall = 3'b001;
        step_clk();
        inCall = 3'b000;
        step_clk();
        checks++; if (pending !== 3'b101 || fault !== 1'b1) begin errors++; $display("FAIL timeout_latch: got pending=%b fault=%b expected 101/1", pending, fault); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (fault !== 1'b0 || pending !== 3'b000) begin errors++; $display("FAIL timeout_rst: got fault=%b pending=%b expected 0/000", fault, pending); end
        apply_reset();
    endtask

    task automatic test_reset_mid_travel();
        apply_reset();
        inCall = 3'b110;
        step_clk();
        inCall = 3'b000;
        step_clk();
        loc = 3'b000;
        step_clk();
        checks++; if (motor !== 2'b10) begin errors++; $display("FAIL midrst_moving: got %b expected 10", motor); end
        #2;
        RST = 1'b1;
        #1;
        checks++; if (motor !== 2'b00 || pending !== 3'b000 || curFloor !== 3'b001) begin errors++; $display("FAIL midrst_async: got motor=%b pending=%b cur=%b expected 00/000/001", motor, pending, curFloor); end
        apply_reset();
    endtask

    task automatic test_door_hold();
        int open_cnt;
        goto_floor2();
`ifdef DOOR_HOLD_EN
        doorHold = 1'b1;
        repeat (20) step_clk();
        doorHold = 1'b0;
        checks++; if (door !== 3'b010) begin errors++; $display("FAIL hold_open: got %b expected 010", door); end
        open_cnt = 0;
        while (door == 3'b010 && open_cnt < 60) begin step_clk(); open_cnt++; end
        checks++; if (20 + open_cnt != 28) begin errors++; $display("FAIL hold_len: got %0d expected 28", 20 + open_cnt); end
`else
        open_cnt = 0;
        while (door == 3'b010 && open_cnt < 60) begin step_clk(); open_cnt++; end
        checks++; if (open_cnt != 8) begin errors++; $display("FAIL nohold_len: got %0d expected 8", open_cnt); end
`endif
    endtask

    task automatic test_random();
        int pos;
        logic [1:0] exp_motor;
        logic [2:0] exp_door;
        apply_reset();
        pos = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            case (pos)
                0: loc = 3'b001;
                3: loc = 3'b010;
                6: loc = 3'b100;
                default: loc = 3'b000;
            endcase
            inCall  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            outCall = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step_clk();
            exp_motor = (m_state == M_UP) ? 2'b10 : (m_state == M_DOWN) ? 2'b11 : 2'b00;
            exp_door  = (m_state == M_DOOR) ? 3'(1 << m_floor) : 3'b000;
            checks++; if (motor !== exp_motor) begin errors++; $display("FAIL rand_motor @%0d: got %b expected %b", cyc, motor, exp_motor); end
            checks++; if (door !== exp_door) begin errors++; $display("FAIL rand_door @%0d: got %b expected %b", cyc, door, exp_door); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rand_pending @%0d: got %b expected %b", cyc, pending, m_pend); end
            checks++; if (curFloor !== 3'(1 << m_floor)) begin errors++; $display("FAIL rand_cur @%0d: got %b expected floor %0d", cyc, curFloor, m_floor); end
            checks++; if (fault !== (m_state == M_FAULT)) begin errors++; $display("FAIL rand_fault @%0d: got %b", cyc, fault); end
            if (motor == 2'b10 && pos < 6) pos++;
            else if (motor == 2'b11 && pos > 0) pos--;
        end
        inCall  = 3'b000;
        outCall = 3'b000;
    endtask

    initial begin
        RST     = 1'b1;
        inCall  = 3'b000;
        outCall = 3'b000;
        loc     = 3'b001;
`ifdef DOOR_HOLD_EN
        doorHold = 1'b0;
`endif
        model_reset();
        test_reset();
        test_up_sweep();
        test_hall_call_here();
        test_scan_priority();
        test_door_restart();
        test_timeout();
        test_reset_mid_travel();
        test_door_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
